// File: rtl/posit_dec_pkg.sv
// Shared constants and the decoded-word record passed between the posit decoder stages.
package posit_dec_pkg;

  localparam int NBITS = 64;
  localparam int ES    = 4;
  localparam int FW    = 57;
  localparam int SW    = 11;

  typedef struct packed {
    logic          sign;
    logic [SW-1:0] scale;
    logic [FW:0]   sig;
    logic          zero;
    logic          nar;
  } posit_dec_t;

endpackage

// File: rtl/posit_scale_calc.sv
// Combinational regime/exponent to scale conversion and hidden-bit insertion.
module posit_scale_calc
  import posit_dec_pkg::*;
(
  input  logic          in_sign,
  input  logic          in_rbit,
  input  logic [5:0]    in_run,
  input  logic [3:0]    in_expo,
  input  logic [FW-1:0] in_frac,
  input  logic          in_zero,
  input  logic          in_nar,
  output posit_dec_t    dec
);

  logic [SW-1:0] run_x;
  logic [SW-1:0] regime;
  logic [SW-1:0] scale;

  assign run_x  = {{(SW-6){1'b0}}, in_run};
  // A run of ones encodes run-1, a run of zeros encodes -run.
  assign regime = in_rbit ? (run_x - SW'(1)) : (SW'(0) - run_x);
  assign scale  = {regime[SW-5:0], 4'b0000} + {{(SW-4){1'b0}}, in_expo};

  always_comb begin
    dec      = '0;
    dec.sign = in_sign;
    if (in_nar) begin
      dec.nar = 1'b1;
    end else if (in_zero) begin
      dec.zero = 1'b1;
    end else begin
      dec.scale = scale;
      dec.sig   = {1'b1, in_frac};
    end
  end

endmodule

// File: rtl/posit_scale_stage.sv
// Two-deep valid/ready stage producing scale and significand, with saturating zero/NaR counters.
module posit_scale_stage #(
  parameter int FW = posit_dec_pkg::FW,
  parameter int SW = posit_dec_pkg::SW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_rbit,
  input  logic [5:0]    in_run,
  input  logic [3:0]    in_expo,
  input  logic [FW-1:0] in_frac,
  input  logic          in_zero,
  input  logic          in_nar,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [SW-1:0] out_scale,
  output logic [FW:0]   out_sig,
  output logic          out_zero,
  output logic          out_nar,
  output logic [CW-1:0] zero_cnt,
  output logic [CW-1:0] nar_cnt
);

  import posit_dec_pkg::*;

  posit_dec_t s1_next;
  posit_dec_t s1_reg;
  posit_dec_t s2_reg;
  logic       v1_reg;
  logic       v2_reg;
  logic       s1_load;
  logic       s2_load;
  logic       fire;
  logic [1:0] hit;

  posit_scale_calc u_calc (
    .in_sign (in_sign),
    .in_rbit (in_rbit),
    .in_run  (in_run),
    .in_expo (in_expo),
    .in_frac (in_frac),
    .in_zero (in_zero),
    .in_nar  (in_nar),
    .dec     (s1_next)
  );

  assign in_ready = !v1_reg || !v2_reg || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = v1_reg && (!v2_reg || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      if (s1_load) begin
        s1_reg <= s1_next;
        v1_reg <= 1'b1;
      end else if (s2_load) begin
        v1_reg <= 1'b0;
      end
      // S2 either takes the S1 word or empties once the consumer has taken it.
      if (s2_load) begin
        s2_reg <= s1_reg;
        v2_reg <= 1'b1;
      end else if (out_ready) begin
        v2_reg <= 1'b0;
      end
    end
  end

  assign out_valid = v2_reg;
  assign out_sign  = s2_reg.sign;
  assign out_scale = s2_reg.scale;
  assign out_sig   = s2_reg.sig;
  assign out_zero  = s2_reg.zero;
  assign out_nar   = s2_reg.nar;

  assign fire = v2_reg && out_ready;
  assign hit  = {s2_reg.nar, s2_reg.zero} & {2{fire}};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CW-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (hit[gi] && (cnt_reg != {CW{1'b1}})) begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  endgenerate

  assign zero_cnt = g_cnt[0].cnt_reg;
  assign nar_cnt  = g_cnt[1].cnt_reg;

  a_run_nonzero : assert property (@(posedge clk) disable iff (!rst_n) in_valid |-> in_run != 6'd0);

endmodule

// File: tb/tb_posit_scale_stage.sv
// Directed bench for posit_scale_stage with a queue-based reference model checked every cycle.
module tb_posit_scale_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic        in_rbit;
  logic [5:0]  in_run;
  logic [3:0]  in_expo;
  logic [56:0] in_frac;
  logic        in_zero;
  logic        in_nar;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [10:0] out_scale;
  logic [57:0] out_sig;
  logic        out_zero;
  logic        out_nar;
  logic [15:0] zero_cnt;
  logic [15:0] nar_cnt;

  always #5 clk = ~clk;

  posit_scale_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_rbit   (in_rbit),
    .in_run    (in_run),
    .in_expo   (in_expo),
    .in_frac   (in_frac),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_scale (out_scale),
    .out_sig   (out_sig),
    .out_zero  (out_zero),
    .out_nar   (out_nar),
    .zero_cnt  (zero_cnt),
    .nar_cnt   (nar_cnt)
  );

  typedef struct {
    logic        sign;
    logic [10:0] scale;
    logic [57:0] sig;
    logic        zero;
    logic        nar;
  } exp_t;

  exp_t q[$];
  int   zseen = 0;
  int   nseen = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic int sat(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  // Reference: value = (+/-)regime * 2^ES + exponent, specials carry no magnitude.
  function automatic exp_t model(input logic s, input logic rbit, input logic [5:0] run,
                                 input logic [3:0] expo, input logic [56:0] frac,
                                 input logic z, input logic n);
    exp_t e;
    int   r;
    int   sc;
    e.sign = s;
    e.nar  = n;
    e.zero = z && !n;
    if (z || n) begin
      e.scale = '0;
      e.sig   = '0;
    end else begin
      r       = rbit ? (int'(run) - 1) : -int'(run);
      sc      = r * 16 + int'(expo);
      e.scale = sc[10:0];
      e.sig   = {1'b1, frac};
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      zseen = 0;
      nseen = 0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_zero_cnt", 64'(zero_cnt), 64'd0);
      chk("rst_nar_cnt", 64'(nar_cnt), 64'd0);
    end else begin
      chk("zero_cnt", 64'(zero_cnt), 64'(sat(zseen)));
      chk("nar_cnt", 64'(nar_cnt), 64'(sat(nseen)));
      if (out_valid) begin
        chk("word_expected", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          e = q[0];
          chk("out_sign", 64'(out_sign), 64'(e.sign));
          chk("out_scale", 64'(out_scale), 64'(e.scale));
          chk("out_sig", 64'(out_sig), 64'(e.sig));
          chk("out_zero", 64'(out_zero), 64'(e.zero));
          chk("out_nar", 64'(out_nar), 64'(e.nar));
          if (out_ready) begin
            void'(q.pop_front());
            if (e.zero) zseen++;
            if (e.nar) nseen++;
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(in_sign, in_rbit, in_run, in_expo, in_frac, in_zero, in_nar));
    end
  end

  task automatic present(input logic s, input logic rbit, input logic [5:0] run,
                         input logic [3:0] expo, input logic [56:0] frac,
                         input logic z, input logic n);
    in_sign  = s;
    in_rbit  = rbit;
    in_run   = run;
    in_expo  = expo;
    in_frac  = frac;
    in_zero  = z;
    in_nar   = n;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic s, input logic rbit, input logic [5:0] run,
                      input logic [3:0] expo, input logic [56:0] frac,
                      input logic z, input logic n);
    int w = 0;
    present(s, rbit, run, expo, frac, z, n);
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int c;
    logic rdy;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    present(0, 1, 6'd1, 4'd0, 57'd0, 0, 0);
    in_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_scale", 64'(out_scale), 64'd0);
    chk("reset_out_sig", 64'(out_sig), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word latency and one-cycle valid pulse.
    send(0, 1, 6'd1, 4'd0, 57'd0, 0, 0);
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_scale", 64'(out_scale), 64'h000);
    chk("t1_sig", 64'(out_sig), 64'h0200_0000_0000_0000);
    @(posedge clk); #1;
    chk("t1_valid_gone", 64'(out_valid), 64'd0);

    send(0, 1, 6'd3, 4'd5, 57'h0AB_CDEF, 0, 0);
    send(1, 0, 6'd2, 4'd15, 57'h1FF_0000_1234, 0, 0);
    chk("t2_scale_pos", 64'(out_scale), 64'h025);
    @(posedge clk); #1;
    chk("t2_scale_neg", 64'(out_scale), 64'h7EF);
    chk("t2_sign", 64'(out_sign), 64'd1);

    send(0, 1, 6'd63, 4'd0, 57'd7, 0, 0);
    @(posedge clk); #1;
    chk("ext_max", 64'(out_scale), 64'h3E0);
    send(0, 0, 6'd63, 4'd0, 57'd9, 0, 0);
    @(posedge clk); #1;
    chk("ext_min", 64'(out_scale), 64'h410);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: four words, consumer stalled.
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      present(0, 1, 6'(acc + 2), 4'(acc + 1), 57'(acc * 3 + 1), 0, 0);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) acc++;
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_scale", 64'(out_scale), 64'h011);
    out_ready = 1'b1;
    c = 0;
    while (acc < 4 && c < 20) begin
      present(0, 1, 6'(acc + 2), 4'(acc + 1), 57'(acc * 3 + 1), 0, 0);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) acc++;
      c++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 64'(acc), 64'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", 64'(q.size()), 64'd0);
    chk("bp_idle", 64'(out_valid), 64'd0);

    // Special values with nonzero fraction.
    send(0, 1, 6'd5, 4'd3, 57'h1_2345_6789, 1, 0);
    send(1, 0, 6'd4, 4'd2, 57'h0FF_FFFF, 0, 1);
    chk("sp_zero_flag", 64'(out_zero), 64'd1);
    chk("sp_zero_sig", 64'(out_sig), 64'd0);
    chk("sp_zero_scale", 64'(out_scale), 64'd0);
    send(0, 1, 6'd2, 4'd7, 57'h555, 1, 1);
    chk("sp_nar_flag", 64'(out_nar), 64'd1);
    chk("sp_nar_sign", 64'(out_sign), 64'd1);
    chk("sp_nar_sig", 64'(out_sig), 64'd0);
    @(posedge clk); #1;
    chk("sp_both_nar", 64'(out_nar), 64'd1);
    chk("sp_both_zero", 64'(out_zero), 64'd0);
    chk("sp_both_scale", 64'(out_scale), 64'd0);
    @(posedge clk); #1;
    chk("sp_zero_cnt", 64'(zero_cnt), 64'd1);
    chk("sp_nar_cnt", 64'(nar_cnt), 64'd2);

    // Saturation of the NaR counter.
    present(0, 1, 6'd1, 4'd0, 57'd0, 0, 1);
    repeat (65537) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_nar_cnt", 64'(nar_cnt), 64'hFFFF);
    chk("sat_zero_cnt", 64'(zero_cnt), 64'd1);

    // Reset in the middle of a stream.
    present(0, 1, 6'd4, 4'd9, 57'h123, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_valid_before", 64'(out_valid), 64'd1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_zero_cnt", 64'(zero_cnt), 64'd0);
    chk("mid_nar_cnt", 64'(nar_cnt), 64'd0);
    chk("mid_out_sig", 64'(out_sig), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_no_replay", 64'(out_valid), 64'd0);
    send(0, 1, 6'd63, 4'd15, 57'h1, 0, 0);
    @(posedge clk); #1;
    chk("post_valid", 64'(out_valid), 64'd1);
    chk("post_scale", 64'(out_scale), 64'h3EF);
    repeat (2) @(posedge clk);
    #1;
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
